// File: rtl/hwpe_ctrl_package.sv
// Shared types for the HWPE control register-file bus target.
package hwpe_ctrl_package;

    // Default response widths; they match the default bus/ID widths of the target.
    localparam int unsigned RespDataWidth = 32;
    localparam int unsigned RespIdWidth   = 8;

    // Target FSM: normal bus service, or a regfile clear that holds off grants.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // One bus response beat at the default widths.
    typedef struct packed {
        logic                     valid;
        logic [RespDataWidth-1:0] data;
        logic [RespIdWidth-1:0]   id;
        logic                     err;
    } regfile_tgt_resp_t;

    // Counter width that still gives one bit when only a single value is needed.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_regfile_addr_dec.sv
// Bus byte-address decode for the control regfile: word index, range check,
// and write protection of the low words while an accelerator job runs.
module hwpe_ctrl_regfile_addr_dec #(
    parameter int unsigned AddrWidth    = 5,
    parameter int unsigned BusAddrWidth = 32,
    parameter int unsigned NumProt      = 4
) (
    input  logic [BusAddrWidth-1:0] add_i,
    input  logic                    busy_i,
    output logic [AddrWidth-1:0]    word_o,
    output logic                    in_range_o,
    output logic                    prot_o
);

    // Byte lane bits carry no meaning for word-wide registers.
    logic [1:0] w_unused_lsb;
    assign w_unused_lsb = add_i[1:0];

    assign word_o     = add_i[AddrWidth+1:2];
    assign in_range_o = (add_i[BusAddrWidth-1:AddrWidth+2] == '0);
    // Only meaningful for writes; the caller qualifies it with the direction.
    assign prot_o     = busy_i && (32'(word_o) < NumProt);

endmodule

// File: rtl/hwpe_ctrl_regfile_target.sv
// Peripheral-bus target owning the write and read ports of the HWPE control
// register file. Accepts req/gnt transfers, issues regfile strobes in the
// acceptance cycle, answers with a fixed one-cycle response, and sequences
// regfile clears while holding off grants.
module hwpe_ctrl_regfile_target
    import hwpe_ctrl_package::*;
#(
    parameter  int unsigned AddrWidth    = 5,
    parameter  int unsigned DataWidth    = 32,
    parameter  int unsigned IdWidth      = 8,
    parameter  int unsigned BusAddrWidth = 32,
    parameter  int unsigned NumProt      = 4,
    parameter  int unsigned ClearCycles  = 2,
    localparam int unsigned NumByte      = DataWidth / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_req_i,
    input  logic                    busy_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [BusAddrWidth-1:0] add_i,
    input  logic                    wen_i,
    input  logic [NumByte-1:0]      be_i,
    input  logic [DataWidth-1:0]    data_i,
    input  logic [IdWidth-1:0]      id_i,
    output logic                    r_valid_o,
    output logic [DataWidth-1:0]    r_data_o,
    output logic [IdWidth-1:0]      r_id_o,
    output logic                    r_err_o,
    output logic                    rf_re_o,
    output logic [AddrWidth-1:0]    rf_raddr_o,
    input  logic [DataWidth-1:0]    rf_rdata_i,
    output logic                    rf_we_o,
    output logic [AddrWidth-1:0]    rf_waddr_o,
    output logic [DataWidth-1:0]    rf_wdata_o,
    output logic [NumByte-1:0]      rf_wbe_o,
    output logic                    rf_clear_o,
    output logic                    clear_busy_o
);

    localparam int unsigned           CntWidth = cnt_width(ClearCycles);
    localparam logic [CntWidth-1:0]   CntLast  = CntWidth'(ClearCycles - 1);

    // Same layout as regfile_tgt_resp_t, sized by this instance's parameters.
    typedef struct packed {
        logic                 valid;
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   id;
        logic                 err;
    } resp_t;

    state_e              r_state;
    logic [CntWidth-1:0] r_cnt;
    resp_t               r_resp;

    logic [AddrWidth-1:0] w_word;
    logic                 w_in_range;
    logic                 w_prot;
    logic                 w_accept;
    logic                 w_err;
    logic                 w_rd_ok;
    logic                 w_wr_ok;

    hwpe_ctrl_regfile_addr_dec #(
        .AddrWidth    (AddrWidth),
        .BusAddrWidth (BusAddrWidth),
        .NumProt      (NumProt)
    ) i_addr_dec (
        .add_i      (add_i),
        .busy_i     (busy_i),
        .word_o     (w_word),
        .in_range_o (w_in_range),
        .prot_o     (w_prot)
    );

    // A clear request wins over a transfer presented in the same IDLE cycle.
    assign gnt_o    = (r_state == IDLE) && !clear_req_i && req_i;
    assign w_accept = req_i && gnt_o;
    assign w_err    = !w_in_range || (!wen_i && w_prot);
    assign w_rd_ok  = w_accept && wen_i && w_in_range;
    assign w_wr_ok  = w_accept && !wen_i && !w_err;

    // Regfile strobes go out in the acceptance cycle; the regfile owns byte masking.
    assign rf_re_o      = w_rd_ok;
    assign rf_raddr_o   = w_word;
    assign rf_we_o      = w_wr_ok;
    assign rf_waddr_o   = w_word;
    assign rf_wdata_o   = data_i;
    assign rf_wbe_o     = be_i;
    assign rf_clear_o   = (r_state == CLEAR);
    assign clear_busy_o = (r_state == CLEAR);

    // Clear sequencer: CLEAR lasts exactly ClearCycles cycles, then one IDLE cycle.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clear_req_i) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (r_cnt == CntLast) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CntWidth'(1'b1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Response register: one beat per accepted transfer; payload holds between beats.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp <= '0;
        end else if (w_accept) begin
            r_resp.valid <= 1'b1;
            r_resp.id    <= id_i;
            r_resp.err   <= w_err;
            r_resp.data  <= w_rd_ok ? rf_rdata_i : '0;
        end else begin
            r_resp.valid <= 1'b0;
        end
    end

    assign r_valid_o = r_resp.valid;
    assign r_data_o  = r_resp.data;
    assign r_id_o    = r_resp.id;
    assign r_err_o   = r_resp.err;

endmodule
